instruction_fetch: RTL and testbench

- Initiator side of the instruction-memory read interface: owns the program counter, drives a word address to instruction_memory and captures the returned word.
- Buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports a branch/jump redirect that flushes in-flight words.
- Sits between instruction_memory (combinational read, word-addressed) and the decode stage.

---
 rtl/instruction_fetch.sv | 196 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Initiator side of the instruction-memory read interface. Owns the program
// counter, presents it as a word address to a combinational-read instruction
// memory, captures the returned word together with the address it came from,
// and buffers both in a small FIFO that feeds decode through a valid/ready
// handshake. A redirect (branch/jump) reloads the PC and flushes the FIFO.
//
// Optional feature (compile-time macro FETCH_BOUNDS_CHECK_EN):
//   When defined, a fetch attempted from pc >= MEM_WORDS is suppressed and a
//   sticky fault is raised. Fetching stays stopped until reset or a redirect
//   to an in-range PC. When undefined, fault is tied low and the PC is simply
//   truncated by the memory's own indexing.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset          in   synchronous, active-high
//   address        out  [ADDR_W]  word address to memory (= current PC)
//   mem_out        in   [DATA_W]  word returned for address, same cycle
//   fetch_en       in   allow new fetches; low freezes PC and enqueue
//   redirect_valid in   load redirect_pc and flush the FIFO
//   redirect_pc    in   [ADDR_W]  new PC
//   inst_valid     out  FIFO head valid
//   inst_ready     in   decode accepts the head
//   inst_out       out  [DATA_W]  head instruction (0 while empty)
//   inst_pc        out  [ADDR_W]  fetch address of the head (0 while empty)
//   fault          out  bounds fault (feature build only, else 0)
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                DEPTH     = 2,
   parameter int                MEM_WORDS = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] mem_out,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_out,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              fault
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] pc_reg,     pc_next;
   logic [CNT_W-1:0]  count_reg,  count_next;
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;

   // FIFO storage; contents need no reset because the outputs are gated by
   // count and a slot is always written before it becomes the head.
   logic [DATA_W-1:0] entry_data_reg [DEPTH];
   logic [ADDR_W-1:0] entry_pc_reg   [DEPTH];
   logic [DEPTH-1:0]  entry_we;

   logic deq;
   logic fetch_try;
   logic enq;
   logic fault_active;

   // ------------------------------------------------------------------
   // Handshake and fetch decision
   // ------------------------------------------------------------------
   assign address    = pc_reg;
   assign inst_valid = (count_reg != '0);
   assign deq        = inst_valid & inst_ready;

   // A slot is available if the FIFO is not full, or if the head leaves in
   // the same cycle (full + deq + enq keeps count at DEPTH).
   assign fetch_try = fetch_en & ~redirect_valid & ~fault_active &
                      ((count_reg < DEPTH_CNT) | deq);

`ifdef FETCH_BOUNDS_CHECK_EN
   logic fault_reg, fault_next;
   logic pc_out_of_range;
   logic redirect_out_of_range;

   // Compare one bit wider so MEM_WORDS == 2**ADDR_W cannot overflow.
   assign pc_out_of_range       = ({1'b0, pc_reg}      >= (ADDR_W+1)'(MEM_WORDS));
   assign redirect_out_of_range = ({1'b0, redirect_pc} >= (ADDR_W+1)'(MEM_WORDS));

   assign fault_active = fault_reg;
   assign enq          = fetch_try & ~pc_out_of_range;
   assign fault        = fault_reg;

   // A redirect clears the fault only when its target is in range; an
   // out-of-range target leaves any existing fault in place and otherwise
   // faults on the next fetch attempt from that PC.
   always_comb begin
      fault_next = fault_reg;
      if (redirect_valid) begin
         fault_next = fault_reg & redirect_out_of_range;
      end else if (fetch_try & pc_out_of_range) begin
         fault_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fault_reg <= 1'b0;
      end else begin
         fault_reg <= fault_next;
      end
   end
`else
   assign fault_active = 1'b0;
   assign enq          = fetch_try;
   assign fault        = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      pc_next     = pc_reg;
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;

      if (redirect_valid) begin
         // Redirect wins over any handshake this cycle: the head being
         // accepted is dropped along with everything else in the FIFO.
         pc_next     = redirect_pc;
         count_next  = '0;
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (enq) begin
            pc_next     = pc_reg + 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
         end
         if (deq) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
         end
         case ({enq, deq})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg     <= RESET_PC;
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         pc_reg     <= pc_next;
         count_reg  <= count_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // ------------------------------------------------------------------
   // FIFO storage: one write enable per slot, written with the PC the word
   // was fetched from so decode sees matching {pc, instruction} pairs.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_we
         assign entry_we[gi] = enq & (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_we[i]) begin
            entry_data_reg[i] <= mem_out;
            entry_pc_reg[i]   <= pc_reg;
         end
      end
   end

   // Head presentation; reads as zero while the FIFO is empty.
   assign inst_out = inst_valid ? entry_data_reg[rd_ptr_reg] : '0;
   assign inst_pc  = inst_valid ? entry_pc_reg[rd_ptr_reg]   : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch with a 32-word combinational instruction memory.
// Part 1 applies a table of per-cycle input records with the outputs expected
// after each clock edge. Part 2 drives random traffic and compares against a
// queue-based reference model. Define FETCH_BOUNDS_CHECK_EN for both the DUT
// and the bench to exercise the bounds fault.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;
   localparam int MWORDS = 32;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] mem_out;
   logic              fetch_en;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_out;
   logic [ADDR_W-1:0] inst_pc;
   logic              fault;

   logic [DATA_W-1:0] memory [MWORDS];

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   assign mem_out = memory[address[4:0]];

   instruction_fetch #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RESET_PC ('0),
      .DEPTH    (DEPTH),
      .MEM_WORDS(MWORDS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .mem_out       (mem_out),
      .fetch_en      (fetch_en),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_out      (inst_out),
      .inst_pc       (inst_pc),
      .fault         (fault)
   );

   // ---------------------------------------------------------------
   // Comparison helper
   // ---------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------
   // Directed vector table: inputs for one cycle, outputs after the edge
   // ---------------------------------------------------------------
   typedef struct {
      logic        rst;
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] eo;
      logic [31:0] epc;
      logic [31:0] ea;
      logic        ef;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic fe, input logic rdy,
                               input logic rv, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] eo,
                               input logic [31:0] epc, input logic [31:0] ea,
                               input logic ef);
      vec_t v;
      v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.eo = eo; v.epc = epc; v.ea = ea; v.ef = ef;
      vecs.push_back(v);
   endfunction

   // Streaming row: head k (fetched from k) and address k+1 after the edge.
   function automatic void add_stream(input int k);
      add(0, 1, 1, 0, 0, 1, k, k, k + 1, 0);
   endfunction

   function automatic void add_reset(input logic rdy);
      add(1, 1, rdy, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // ---------------------------------------------------------------
   // Reference model state (random phase)
   // ---------------------------------------------------------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   entry_t      m_q[$];
   logic [31:0] m_pc;
   logic        m_fault;

   task automatic model_step(input logic rst, input logic fe, input logic rdy,
                             input logic rv, input logic [31:0] rpc, input int cyc);
      int     size_before;
      logic   m_deq;
      entry_t e;
      if (rst) begin
         m_q.delete();
         m_pc    = '0;
         m_fault = 1'b0;
         return;
      end
      size_before = m_q.size();
      m_deq = (size_before > 0) && rdy;
      if (rv) begin
         m_q.delete();
         m_pc = rpc;
         if (BOUNDS && rpc < MWORDS) m_fault = 1'b0;
         return;
      end
      if (m_deq) begin
         e = m_q.pop_front();
         $display("[rand %0d] accept pc=%h inst=%h", cyc, e.pc, e.data);
      end
      if (fe && !m_fault && (size_before < DEPTH || m_deq)) begin
         if (BOUNDS && m_pc >= MWORDS) begin
            m_fault = 1'b1;
         end else begin
            e.pc   = m_pc;
            e.data = memory[m_pc[4:0]];
            m_q.push_back(e);
            m_pc = m_pc + 1;
         end
      end
   endtask

   // ---------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------
   initial begin
      reset          = 1'b1;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;
      for (int k = 0; k < MWORDS; k++) memory[k] = k;

      // Basic stream after a 2-cycle reset.
      add_reset(1); add_reset(1);
      for (int k = 0; k < 4; k++) add_stream(k);

      // Decode stalled: fill to DEPTH, PC holds, then drain with no gap.
      add_reset(0);
      add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
      add(0, 1, 0, 0, 0, 1, 0, 0, 2, 0);
      add(0, 1, 0, 0, 0, 1, 0, 0, 2, 0);
      for (int k = 1; k < 4; k++) add(0, 1, 1, 0, 0, 1, k, k, k + 2, 0);

      // Redirect at pc=5 kills the head handshake; target appears 2 cycles on.
      add_reset(1);
      for (int k = 0; k < 5; k++) add_stream(k);
      add(0, 1, 1, 1, 20, 0, 0, 0, 20, 0);
      for (int k = 20; k < 23; k++) add_stream(k);

      // fetch_en low at pc=4: FIFO drains, address frozen.
      add_reset(1);
      for (int k = 0; k < 4; k++) add_stream(k);
      for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0, 0, 0, 0, 4, 0);
      add_stream(4);
      add_stream(5);

      // Reset while full at pc=9.
      add_reset(1);
      for (int k = 0; k < 8; k++) add_stream(k);
      add(0, 1, 0, 0, 0, 1, 7, 7, 9, 0);
      add(0, 1, 0, 0, 0, 1, 7, 7, 9, 0);
      add_reset(0);
      add_stream(0);

`ifdef FETCH_BOUNDS_CHECK_EN
      // Run off the end of memory, then recover by redirect.
      add_reset(1);
      add(0, 1, 1, 1, 30, 0, 0, 0, 30, 0);
      add_stream(30);
      add_stream(31);
      add(0, 1, 1, 0, 0, 0, 0, 0, 32, 1);
      add(0, 1, 1, 0, 0, 0, 0, 0, 32, 1);
      add(0, 1, 1, 1, 3, 0, 0, 0, 3, 0);
      add_stream(3);
`else
      // PC wraps modulo 2^ADDR_W; memory index truncates.
      add_reset(1);
      add(0, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF, 0);
      add(0, 1, 1, 0, 0, 1, 31, 32'hFFFF_FFFF, 0, 0);
      add_stream(0);
`endif

      foreach (vecs[i]) begin
         reset          = vecs[i].rst;
         fetch_en       = vecs[i].fe;
         inst_ready     = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         @(posedge clk);
         #1;
         $display("[vec %0d] rst=%b fe=%b rdy=%b rv=%b -> valid=%b out=%h pc=%h addr=%h fault=%b",
                  i, vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].rv,
                  inst_valid, inst_out, inst_pc, address, fault);
         chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d inst_out", i), inst_out, vecs[i].eo);
         chk($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].epc);
         chk($sformatf("vec%0d address", i), address, vecs[i].ea);
         chk($sformatf("vec%0d fault", i), 32'(fault), 32'(vecs[i].ef));
      end

      // ---------------------------------------------------------------
      // Random phase against the reference model
      // ---------------------------------------------------------------
      for (int k = 0; k < MWORDS; k++) memory[k] = $urandom;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      model_step(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      for (int cyc = 0; cyc < 600; cyc++) begin
         logic        r_rst, r_fe, r_rdy, r_rv;
         logic [31:0] r_rpc;

         chk($sformatf("rand%0d inst_valid", cyc), 32'(inst_valid), 32'(m_q.size() != 0));
         chk($sformatf("rand%0d address", cyc), address, m_pc);
         chk($sformatf("rand%0d fault", cyc), 32'(fault), 32'(m_fault));
         if (m_q.size() != 0) begin
            chk($sformatf("rand%0d inst_out", cyc), inst_out, m_q[0].data);
            chk($sformatf("rand%0d inst_pc", cyc), inst_pc, m_q[0].pc);
         end else begin
            chk($sformatf("rand%0d inst_out empty", cyc), inst_out, 32'h0);
         end

         r_rst = ($urandom_range(0, 79) == 0);
         r_fe  = ($urandom_range(0, 3) != 0);
         r_rdy = ($urandom_range(0, 2) != 0);
         r_rv  = ($urandom_range(0, 14) == 0);
         case ($urandom_range(0, 3))
            0:       r_rpc = 32'hFFFF_FFFE;
            1:       r_rpc = $urandom;
            default: r_rpc = $urandom_range(0, 40);
         endcase

         reset          = r_rst;
         fetch_en       = r_fe;
         inst_ready     = r_rdy;
         redirect_valid = r_rv;
         redirect_pc    = r_rpc;
         model_step(r_rst, r_fe, r_rdy, r_rv, r_rpc, cyc);
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
